// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to downstream pixel stages.
//   vga_clk      pixel clock (system clock / 2)
//   DrawX/DrawY  current column / row
//   blank        1 = visible pixel, 0 = blanking
//   hs/vs        horizontal / vertical sync, active low
//   sync         composite sync to DAC (constant 0)
//   line_start   high for the pixel period where DrawX == 0
//   frame_start  high for the pixel period where DrawX == 0 && DrawY == 0
interface vga_timing_gen_if;
  logic       vga_clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       sync;
  logic       line_start;
  logic       frame_start;

  modport master (
    output vga_clk, DrawX, DrawY, blank, hs, vs, sync, line_start, frame_start
  );

  modport slave (
    input vga_clk, DrawX, DrawY, blank, hs, vs, sync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: halves Clk into vga_clk and runs the horizontal and
// vertical pixel counters with their blank/sync/strobe flags.
//   Clk      in   system clock (only clock in the block)
//   reset_n  in   asynchronous active-low reset
//   vga      out  raster bundle (vga_timing_gen_if.master)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic               Clk,
  input  logic               reset_n,
  vga_timing_gen_if.master   vga
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic          vga_clk_q;
  logic [CW-1:0] draw_x_q;
  logic [CW-1:0] draw_y_q;
  logic          blank_q;
  logic          hs_q;
  logic          vs_q;
  logic          line_start_q;
  logic          frame_start_q;

  logic [CW-1:0] draw_x_nxt_c;
  logic [CW-1:0] draw_y_nxt_c;
  logic          blank_nxt_c;
  logic          hs_nxt_c;
  logic          vs_nxt_c;
  logic          line_start_nxt_c;
  logic          frame_start_nxt_c;

  // Next raster position and the flags that belong to it, so the registered
  // flags always line up with the registered position.
  always_comb begin
    draw_x_nxt_c = draw_x_q + CW'(1);
    draw_y_nxt_c = draw_y_q;
    if (draw_x_q == H_LAST) begin
      draw_x_nxt_c = '0;
      draw_y_nxt_c = (draw_y_q == V_LAST) ? '0 : draw_y_q + CW'(1);
    end
    blank_nxt_c       = (draw_x_nxt_c < H_VIS) && (draw_y_nxt_c < V_VIS);
    hs_nxt_c          = !((draw_x_nxt_c >= HS_BEG) && (draw_x_nxt_c < HS_END));
    vs_nxt_c          = !((draw_y_nxt_c >= VS_BEG) && (draw_y_nxt_c < VS_END));
    line_start_nxt_c  = (draw_x_nxt_c == '0);
    frame_start_nxt_c = (draw_x_nxt_c == '0) && (draw_y_nxt_c == '0);
  end

  // Pixel clock toggles every Clk; the raster steps on the edge where it rises.
  // Reset parks the counters on the last pixel so the first step lands on (0,0).
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_clk_q     <= 1'b0;
      draw_x_q      <= H_LAST;
      draw_y_q      <= V_LAST;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vga_clk_q <= ~vga_clk_q;
      if (!vga_clk_q) begin
        draw_x_q      <= draw_x_nxt_c;
        draw_y_q      <= draw_y_nxt_c;
        blank_q       <= blank_nxt_c;
        hs_q          <= hs_nxt_c;
        vs_q          <= vs_nxt_c;
        line_start_q  <= line_start_nxt_c;
        frame_start_q <= frame_start_nxt_c;
      end
    end
  end

  assign vga.vga_clk     = vga_clk_q;
  assign vga.DrawX       = draw_x_q;
  assign vga.DrawY       = draw_y_q;
  assign vga.blank       = blank_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.sync        = 1'b0;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
